// File: rtl/unidade_controle_jogadas.sv
// Control FSM for the play round: drives zera/carrega/conta into the count-and-compare
// datapath and ends the round on last play, mismatch or timeout.
module unidade_controle_jogadas #(
  parameter int TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim,
  output logic       zera,
  output logic       carrega,
  output logic       conta,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h3,
    COMPARACAO  = 4'h4,
    PROXIMO     = 4'h5,
    FIM_ACERTO  = 4'hA,
    FIM_TIMEOUT = 4'hD,
    FIM_ERRO    = 4'hE
  } estado_t;

  estado_t        estado_q, estado_d;
  logic           jogada_q, jogada_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           jogada_pulso;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
      jogada_q <= 1'b0;
      timer_q  <= '0;
    end else begin
      estado_q <= estado_d;
      jogada_q <= jogada_d;
      timer_q  <= timer_d;
    end
  end

  assign jogada_pulso = jogada & ~jogada_q;

  always_comb begin
    estado_d = estado_q;
    jogada_d = jogada;
    timer_d  = '0;
    case (estado_q)
      INICIAL:    if (iniciar) estado_d = PREPARACAO;
      PREPARACAO: estado_d = ESPERA;
      ESPERA: begin
        // A press in the last timer cycle still counts as a play.
        if (jogada_pulso)             estado_d = REGISTRA;
        else if (timer_q == TIMER_LAST) estado_d = FIM_TIMEOUT;
        else                          timer_d  = timer_q + TW'(1);
      end
      REGISTRA:   estado_d = COMPARACAO;
      COMPARACAO: begin
        if (!igual)   estado_d = FIM_ERRO;
        else if (fim) estado_d = FIM_ACERTO;
        else          estado_d = PROXIMO;
      end
      PROXIMO:    estado_d = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT:
                  if (iniciar) estado_d = PREPARACAO;
      default:    estado_d = INICIAL;
    endcase
  end

  // Moore outputs, decoded from the registered state only.
  always_comb begin
    zera    = 1'b0;
    carrega = 1'b0;
    conta   = 1'b0;
    pronto  = 1'b0;
    acertou = 1'b0;
    errou   = 1'b0;
    timeout = 1'b0;
    case (estado_q)
      PREPARACAO:  zera    = 1'b1;
      REGISTRA:    carrega = 1'b1;
      PROXIMO:     conta   = 1'b1;
      FIM_ACERTO:  begin pronto = 1'b1; acertou = 1'b1; end
      FIM_ERRO:    begin pronto = 1'b1; errou   = 1'b1; end
      FIM_TIMEOUT: begin pronto = 1'b1; timeout = 1'b1; end
      default:     ;
    endcase
  end

  assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogadas.sv
// Directed bench for unidade_controle_jogadas with TIMEOUT=10.
module tb_unidade_controle_jogadas;

  logic       clock, reset, iniciar, jogada, igual, fim;
  logic       zera, carrega, conta, pronto, acertou, errou, timeout;
  logic [3:0] db_estado;

  int n_vec = 0;
  int n_err = 0;
  int cnt_z = 0, cnt_c = 0, cnt_n = 0;
  int cyc;

  unidade_controle_jogadas #(.TIMEOUT(10)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .fim(fim), .zera(zera), .carrega(carrega), .conta(conta),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .db_estado(db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected {zera,carrega,conta,pronto,acertou,errou,timeout} per state.
  function automatic logic [6:0] outs_of(input logic [3:0] s);
    case (s)
      4'h1:    return 7'b1000000;
      4'h3:    return 7'b0100000;
      4'h5:    return 7'b0010000;
      4'hA:    return 7'b0001100;
      4'hE:    return 7'b0001010;
      4'hD:    return 7'b0001001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] s);
    chk({tag, " estado"}, {28'd0, db_estado}, {28'd0, s});
    chk({tag, " saidas"}, {25'd0, zera, carrega, conta, pronto, acertou, errou, timeout},
        {25'd0, outs_of(s)});
  endtask

  // Tally control pulses of the current cycle, then advance one clock.
  task automatic step();
    cnt_z += int'(zera);
    cnt_c += int'(carrega);
    cnt_n += int'(conta);
    @(posedge clock);
    #1;
  endtask

  task automatic clr_cnt();
    cnt_z = 0; cnt_c = 0; cnt_n = 0;
  endtask

  // From espera: one press, then follow registra -> comparacao -> outcome.
  task automatic play(input string tag, input logic ig, input logic fm, input logic [3:0] fin);
    jogada = 1'b1; igual = ig; fim = fm;
    step();
    chk_state({tag, " registra"}, 4'h3);
    jogada = 1'b0;
    step();
    chk_state({tag, " comparacao"}, 4'h4);
    step();
    chk_state({tag, " resultado"}, fin);
    if (fin == 4'h5) begin
      step();
      chk_state({tag, " espera"}, 4'h2);
    end
  endtask

  task automatic start_round(input string tag);
    iniciar = 1'b1;
    step();
    chk_state({tag, " preparacao"}, 4'h1);
    iniciar = 1'b0;
    step();
    chk_state({tag, " espera"}, 4'h2);
  endtask

  task automatic count_espera(output int n);
    n = 0;
    while (db_estado == 4'h2 && n < 50) begin
      n++;
      step();
    end
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fim = 1'b0;
    step(); step();
    chk_state("reset ativo", 4'h0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk_state("inicial parado", 4'h0);

    // Full correct round: 15 plays to proximo, 16th hits fim.
    clr_cnt();
    start_round("rodada");
    for (int i = 0; i < 15; i++) play("jogada ok", 1'b1, 1'b0, 4'h5);
    play("ultima jogada", 1'b1, 1'b1, 4'hA);
    step();
    chk_state("acerto mantido", 4'hA);
    chk("zera pulsos", cnt_z, 1);
    chk("carrega pulsos", cnt_c, 16);
    chk("conta pulsos", cnt_n, 15);

    // Mismatch on third play.
    clr_cnt();
    start_round("erro");
    play("erro j1", 1'b1, 1'b0, 4'h5);
    play("erro j2", 1'b1, 1'b0, 4'h5);
    play("erro j3", 1'b0, 1'b0, 4'hE);
    chk("conta no erro", cnt_n, 2);

    // Restart from fim_erro, then timeout with no plays.
    start_round("reinicio");
    count_espera(cyc);
    chk("ciclos espera", cyc, 10);
    chk_state("timeout", 4'hD);

    // A play late in the window restarts the full window.
    start_round("janela");
    for (int i = 0; i < 8; i++) step();
    play("janela jogada", 1'b1, 1'b0, 4'h5);
    count_espera(cyc);
    chk("ciclos janela nova", cyc, 10);
    chk_state("timeout janela", 4'hD);

    // Held button: one carrega only, then the window runs out.
    start_round("segurado");
    clr_cnt();
    jogada = 1'b1; igual = 1'b1; fim = 1'b0;
    for (int i = 0; i < 20; i++) step();
    jogada = 1'b0;
    chk("carrega segurado", cnt_c, 1);
    chk_state("segurado fim", 4'hD);

    // Press in the timer==9 cycle wins over the timeout.
    start_round("simultaneo");
    for (int i = 0; i < 9; i++) step();
    chk_state("timer nove", 4'h2);
    jogada = 1'b1;
    step();
    chk_state("pulso vence", 4'h3);
    jogada = 1'b0;
    step();
    step();
    chk_state("proximo", 4'h5);

    // Asynchronous reset mid-round, checked before any clock edge.
    #2 reset = 1'b0;
    #1;
    chk_state("reset assincrono", 4'h0);
    #3 reset = 1'b1;
    step();
    chk_state("apos reset", 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
